// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel one-shot pulse generator.
// Holds the per-channel state encoding and the pulse-length clamp.
package pulse_gen_pkg;

    localparam int MAX_LEN_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        HOLD     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // Counter load value for a pulse: a length of 0 behaves like a length of 1.
    function automatic logic [MAX_LEN_W-1:0] pulse_count(input logic [MAX_LEN_W-1:0] len);
        return (len == '0) ? '0 : len - MAX_LEN_W'(1);
    endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse-generator channel: edge register, length down-counter and a
// four-state FSM that emits a pulse, holds off, then waits for re-arm.
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic [LEN_W-1:0] pulse_len,
    input  logic [LEN_W-1:0] holdoff_len,
    input  logic             repeat_en,
    output logic             out,
    output logic             busy,
    output logic             missed
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;
    logic [LEN_W-1:0] pulse_load;
    logic             in_q;
    logic             missed_next;

    assign pulse_load  = LEN_W'(pulse_count(MAX_LEN_W'(pulse_len)));
    assign missed_next = in & ~in_q & ((state == PULSE) || (state == HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            in_q   <= 1'b0;
            missed <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            in_q   <= in;
            missed <= missed_next;
        end
    end

    // Transitions are taken when the counter reaches zero, so it never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (in) begin
                    state_next = PULSE;
                    cnt_next   = pulse_load;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - LEN_W'(1);
                end else if (holdoff_len != '0) begin
                    state_next = HOLD;
                    cnt_next   = holdoff_len - LEN_W'(1);
                end else begin
                    state_next = WAIT_LOW;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = WAIT_LOW;
                end else begin
                    cnt_next = cnt - LEN_W'(1);
                end
            end
            WAIT_LOW: begin
                if (!in) begin
                    state_next = IDLE;
                end else if (repeat_en) begin
                    state_next = PULSE;
                    cnt_next   = pulse_load;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        out  = (state == PULSE);
        busy = (state != IDLE);
    end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel one-shot pulse generator: independent channels sharing only
// the pulse-length and hold-off settings.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [LEN_W-1:0]    pulse_len,
    input  logic [LEN_W-1:0]    holdoff_len,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] missed
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pulse_gen_channel #(
            .LEN_W(LEN_W)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .in         (in[g]),
            .pulse_len  (pulse_len),
            .holdoff_len(holdoff_len),
            .repeat_en  (repeat_en[g]),
            .out        (out[g]),
            .busy       (busy[g]),
            .missed     (missed[g])
        );
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen with 4 channels and 8-bit lengths.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pulse_gen;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic [7:0] pulse_len;
    logic [7:0] holdoff_len;
    logic [3:0] repeat_en;
    logic [3:0] out;
    logic [3:0] busy;
    logic [3:0] missed;

    int checks;
    int errors;
    int high_count;

    pulse_gen #(
        .CHANNELS(4),
        .LEN_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .pulse_len  (pulse_len),
        .holdoff_len(holdoff_len),
        .repeat_en  (repeat_en),
        .out        (out),
        .busy       (busy),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_v, input logic [3:0] in_v);
        rst = rst_v;
        in  = in_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in          = 4'h0;
        pulse_len   = 8'd3;
        holdoff_len = 8'd0;
        repeat_en   = 4'h0;

        // Reset held with all inputs high: nothing may fire.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'hF);
            checkOutput("reset_out", 32'(out), 32'h0);
            checkOutput("reset_busy", 32'(busy), 32'h0);
            checkOutput("reset_missed", 32'(missed), 32'h0);
        end
        applyStimulus(1'b0, 4'hF);
        checkOutput("post_reset_out", 32'(out), 32'hF);
        checkOutput("post_reset_busy", 32'(busy), 32'hF);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0);
        checkOutput("post_reset_idle", 32'(busy), 32'h0);

        $display("[TB] basic pulse");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'b0001);
            checkOutput("basic_out", 32'(out), (i < 3) ? 32'h1 : 32'h0);
            checkOutput("basic_busy", 32'(busy), 32'h1);
        end
        applyStimulus(1'b0, 4'h0);
        checkOutput("basic_busy_fall", 32'(busy), 32'h0);

        $display("[TB] repeat mode");
        pulse_len   = 8'd2;
        holdoff_len = 8'd4;
        repeat_en   = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 4'b0010);
            checkOutput("repeat_out", 32'(out), ((i % 7) < 2) ? 32'h2 : 32'h0);
        end
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("repeat_release_out", 32'(out), 32'h0);
        end
        checkOutput("repeat_release_busy", 32'(busy), 32'h0);

        $display("[TB] missed edge");
        pulse_len   = 8'd5;
        holdoff_len = 8'd5;
        repeat_en   = 4'h0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, (i == 0 || i == 4) ? 4'b0100 : 4'b0000);
            checkOutput("missed_out", 32'(out), (i < 5) ? 32'h4 : 32'h0);
            checkOutput("missed_strobe", 32'(missed), (i == 4) ? 32'h4 : 32'h0);
            checkOutput("missed_busy", 32'(busy), (i <= 10) ? 32'h4 : 32'h0);
        end

        $display("[TB] zero and maximum lengths");
        pulse_len   = 8'd0;
        holdoff_len = 8'd0;
        applyStimulus(1'b0, 4'b0001);
        checkOutput("zero_len_out", 32'(out), 32'h1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("zero_len_after_out", 32'(out), 32'h0);
        checkOutput("zero_hold_waitlow_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("zero_hold_idle_busy", 32'(busy), 32'h0);

        pulse_len  = 8'd255;
        high_count = 0;
        applyStimulus(1'b0, 4'b0001);
        if (out[0]) high_count++;
        for (int i = 1; i < 300; i++) begin
            applyStimulus(1'b0, 4'h0);
            if (out[0]) high_count++;
        end
        checkOutput("max_len_count", 32'(high_count), 32'd255);
        checkOutput("max_len_idle", 32'(busy), 32'h0);

        $display("[TB] reset mid-pulse");
        pulse_len = 8'd10;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, (i == 0) ? 4'b1000 : 4'b0000);
            checkOutput("midreset_out_before", 32'(out), 32'h8);
        end
        applyStimulus(1'b1, 4'b1000);
        checkOutput("midreset_out", 32'(out), 32'h0);
        checkOutput("midreset_missed", 32'(missed), 32'h0);
        checkOutput("midreset_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("midreset_release_busy", 32'(busy), 32'h0);
        checkOutput("midreset_release_missed", 32'(missed), 32'h0);

        $display("[TB] channel independence");
        repeat_en = 4'b0001;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b0, 4'b1001);
            checkOutput("indep_out", 32'(out),
                        32'({(i < 10) ? 1'b1 : 1'b0, 2'b00, ((i % 11) < 10) ? 1'b1 : 1'b0}));
            checkOutput("indep_missed", 32'(missed), 32'h0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
